wide_add_sequencer: RTL

//  Multi-cycle controller that adds two NBYTES-byte operands through the shared 8-bit ripple adder, one byte per cycle.

---
 rtl/wide_add_pkg.sv | 17 +
 rtl/wide_add_sequencer_operand_shifter.sv | 53 +++++
 rtl/wide_add_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/wide_add_pkg.sv
// Shared definitions for the wide add sequencer: byte width, FSM state encoding
// and the byte-index width helper.
package wide_add_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/wide_add_sequencer_operand_shifter.sv
// Holds both operands and shifts them down one byte per RUN cycle so the
// current byte is always the low byte; no indexed muxing needed upstream.
module operand_shifter
    import wide_add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       load_i,
    input  logic                       shift_i,
    input  logic [BYTE_W*NBYTES-1:0]   opa_i,
    input  logic [BYTE_W*NBYTES-1:0]   opb_i,
    output logic [BYTE_W-1:0]          a_byte_o,
    output logic [BYTE_W-1:0]          b_byte_o
);

    localparam int W = BYTE_W * NBYTES;

    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;

    // Next operand contents: load on accept, shift during RUN, else hold.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (load_i) begin
            a_d = opa_i;
            b_d = opb_i;
        end else if (shift_i) begin
            a_d = {{BYTE_W{1'b0}}, a_q[W-1:BYTE_W]};
            b_d = {{BYTE_W{1'b0}}, b_q[W-1:BYTE_W]};
        end else begin
            a_d = a_q;
            b_d = b_q;
        end
    end

    // Operand registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q <= {W{1'b0}};
            b_q <= {W{1'b0}};
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign a_byte_o = a_q[BYTE_W-1:0];
    assign b_byte_o = b_q[BYTE_W-1:0];

endmodule

// File: rtl/wide_add_sequencer.sv
// Byte-serial wide adder controller driving an external 8-bit adder.
// Optional subtract support is enabled by defining WIDE_ADD_SUB_EN.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      START,
    input  logic [BYTE_W*NBYTES-1:0]  OPA,
    input  logic [BYTE_W*NBYTES-1:0]  OPB,
    input  logic                      CIN,
    input  logic                      SUB,
    output logic [BYTE_W-1:0]         ADD_A,
    output logic [BYTE_W-1:0]         ADD_B,
    output logic                      ADD_CI,
    input  logic [BYTE_W-1:0]         ADD_Y,
    input  logic                      ADD_C,
    input  logic                      ADD_V,
    output logic [BYTE_W*NBYTES-1:0]  SUM,
    output logic                      COUT,
    output logic                      OVF,
    output logic                      BUSY,
    output logic                      DONE
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = idx_width(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               cin_q, cin_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               sub_q, sub_d;
    logic               load_s;
    logic               shift_s;
    logic [BYTE_W-1:0]  a_byte_s;
    logic [BYTE_W-1:0]  b_byte_s;
    logic [BYTE_W-1:0]  b_eff_s;
    logic               ci0_s;

    operand_shifter #(
        .NBYTES (NBYTES)
    ) u_shifter (
        .clk_i    (CLK),
        .rst_i    (RST),
        .load_i   (load_s),
        .shift_i  (shift_s),
        .opa_i    (OPA),
        .opb_i    (OPB),
        .a_byte_o (a_byte_s),
        .b_byte_o (b_byte_s)
    );

`ifdef WIDE_ADD_SUB_EN
    // Subtract is A + ~B + 1; CIN is not used for a subtract.
    always_comb begin
        if (sub_q) begin
            b_eff_s = ~b_byte_s;
            ci0_s   = 1'b1;
        end else begin
            b_eff_s = b_byte_s;
            ci0_s   = cin_q;
        end
    end
`else
    logic unused_sub_s;
    assign unused_sub_s = sub_q;
    assign b_eff_s      = b_byte_s;
    assign ci0_s        = cin_q;
`endif

    // Next-state, result accumulation and operand-shifter control.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cin_d   = cin_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        sub_d   = sub_q;
        load_s  = 1'b0;
        shift_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d = ST_RUN;
                    load_s  = 1'b1;
                    cin_d   = CIN;
                    sub_d   = SUB;
                    sum_d   = {W{1'b0}};
                    idx_d   = ZERO_IDX;
                    carry_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sum_d[idx_q*BYTE_W +: BYTE_W] = ADD_Y;
                carry_d = ADD_C;
                shift_s = 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = ADD_C;
                    ovf_d   = ADD_V;
                    idx_d   = ZERO_IDX;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= ZERO_IDX;
            carry_q <= 1'b0;
            cin_q   <= 1'b0;
            sum_q   <= {W{1'b0}};
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cin_q   <= cin_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            sub_q   <= sub_d;
        end
    end

    // Adder inputs are driven only while running; byte 0 takes the initial carry.
    always_comb begin
        if (state_q == ST_RUN) begin
            ADD_A  = a_byte_s;
            ADD_B  = b_eff_s;
            if (idx_q == ZERO_IDX) begin
                ADD_CI = ci0_s;
            end else begin
                ADD_CI = carry_q;
            end
        end else begin
            ADD_A  = {BYTE_W{1'b0}};
            ADD_B  = {BYTE_W{1'b0}};
            ADD_CI = 1'b0;
        end
    end

    assign SUM  = sum_q;
    assign COUT = cout_q;
    assign OVF  = ovf_q;
    assign BUSY = (state_q == ST_RUN);
    assign DONE = (state_q == ST_DONE);

endmodule
